// File: rtl/pc_sequencer.sv
// pc_sequencer: IF-stage program counter with prioritised next-PC selection, misalign flag and redirect counter
module pc_sequencer #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h00400000),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h00400004),
  parameter int INC = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [15:0]      br_imm,
  input  logic             j_en,
  input  logic [25:0]      j_index,
  input  logic             jr_en,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc_in,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pc_valid,
  output logic             misalign,
  output logic [CNT_W-1:0] redir_cnt
);
  logic [WIDTH-1:0] nxt, br_tgt, j_tgt;
  logic jr_bad, redir, set_mis;
  assign pc_plus = pc + WIDTH'(INC);
  assign br_tgt = pc_plus + {{(WIDTH-18){br_imm[15]}}, br_imm, 2'b00};
  assign j_tgt = {pc_plus[WIDTH-1:28], j_index, 2'b00};
  assign jr_bad = jr_addr[1:0] != 2'b00;
  // Next-PC priority: exception, eret, stall, jr, j, branch, sequential
  always_comb begin
    nxt = exc_req ? EXC_VECTOR :
          eret ? epc_in :
          stall ? pc :
          jr_en ? (jr_bad ? EXC_VECTOR : jr_addr) :
          j_en ? j_tgt :
          br_taken ? br_tgt : pc_plus;
    redir = exc_req | eret | (!stall & (jr_en | j_en | br_taken));
    set_mis = !exc_req & !eret & !stall & jr_en & jr_bad;
  end
  // PC register, validity, sticky misalign and saturating redirect counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
      pc_valid <= 1'b0;
      misalign <= 1'b0;
      redir_cnt <= '0;
    end else begin
      pc <= nxt;
      pc_valid <= 1'b1;
      misalign <= misalign | set_mis;
      if (redir && redir_cnt != '1) redir_cnt <= redir_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0, br_taken = 1'b0, j_en = 1'b0, jr_en = 1'b0, exc_req = 1'b0, eret = 1'b0;
  logic [15:0] br_imm = '0;
  logic [25:0] j_index = '0;
  logic [31:0] jr_addr = '0, epc_in = '0;
  logic [31:0] pc, pc_plus, pc2, pc_plus2;
  logic pc_valid, misalign, pc_valid2, misalign2;
  logic [15:0] redir_cnt;
  logic [1:0] redir_cnt2;
  typedef struct {
    logic [31:0] pc;
    logic v;
    logic m;
    logic [31:0] c;
    logic [31:0] c2;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int passed = 0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_imm(br_imm),
    .j_en(j_en), .j_index(j_index), .jr_en(jr_en), .jr_addr(jr_addr),
    .exc_req(exc_req), .eret(eret), .epc_in(epc_in),
    .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid), .misalign(misalign), .redir_cnt(redir_cnt)
  );

  pc_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_imm(br_imm),
    .j_en(j_en), .j_index(j_index), .jr_en(jr_en), .jr_addr(jr_addr),
    .exc_req(exc_req), .eret(eret), .epc_in(epc_in),
    .pc(pc2), .pc_plus(pc_plus2), .pc_valid(pc_valid2), .misalign(misalign2), .redir_cnt(redir_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expectation for the coming edge is queued, then requests are cleared after it
  task automatic cyc(input logic c, input logic [31:0] p, input logic v, input logic m,
                     input logic [31:0] n, input logic [31:0] n2);
    exp_t e;
    e.pc = p; e.v = v; e.m = m; e.c = n; e.c2 = n2;
    if (c) q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    stall = 0; br_taken = 0; br_imm = '0; j_en = 0; j_index = '0;
    jr_en = 0; jr_addr = '0; exc_req = 0; eret = 0; epc_in = '0;
  endtask

  // Monitor: after each edge, pop the queued expectation and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus", pc_plus, e.pc + 32'd4);
        chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.v});
        chk("misalign", {31'd0, misalign}, {31'd0, e.m});
        chk("redir_cnt", {16'd0, redir_cnt}, e.c);
        chk("redir_cnt_w2", {30'd0, redir_cnt2}, e.c2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h00400000, 0, 0, 0, 0);
    rst = 0;
    cyc(1, 32'h00400004, 1, 0, 0, 0);
    cyc(1, 32'h00400008, 1, 0, 0, 0);
    cyc(1, 32'h0040000C, 1, 0, 0, 0);
    cyc(1, 32'h00400010, 1, 0, 0, 0);
    br_taken = 1; br_imm = 16'hFFFC;
    cyc(1, 32'h00400004, 1, 0, 1, 1);
    cyc(1, 32'h00400008, 1, 0, 1, 1);
    cyc(1, 32'h0040000C, 1, 0, 1, 1);
    cyc(1, 32'h00400010, 1, 0, 1, 1);
    stall = 1; br_taken = 1; br_imm = 16'hFFFC;
    cyc(1, 32'h00400010, 1, 0, 1, 1);
    cyc(1, 32'h00400014, 1, 0, 1, 1);
    cyc(1, 32'h00400018, 1, 0, 1, 1);
    cyc(1, 32'h0040001C, 1, 0, 1, 1);
    cyc(1, 32'h00400020, 1, 0, 1, 1);
    j_en = 1; j_index = 26'h0100008;
    cyc(1, 32'h00400020, 1, 0, 2, 2);
    jr_en = 1; jr_addr = 32'h00400102;
    cyc(1, 32'h00400004, 1, 1, 3, 3);
    exc_req = 1; stall = 1; j_en = 1; j_index = 26'h3FFFFFF;
    cyc(1, 32'h00400004, 1, 1, 4, 3);
    eret = 1; epc_in = 32'h00400050;
    cyc(1, 32'h00400050, 1, 1, 5, 3);
    eret = 1; stall = 1; epc_in = 32'h00400100;
    cyc(1, 32'h00400100, 1, 1, 6, 3);
    jr_en = 1; jr_addr = 32'h00400200; j_en = 1; j_index = 26'h3FFFFFF; br_taken = 1; br_imm = 16'h0010;
    cyc(1, 32'h00400200, 1, 1, 7, 3);
    j_en = 1; j_index = 26'h0100040; br_taken = 1; br_imm = 16'h0010;
    cyc(1, 32'h00400100, 1, 1, 8, 3);
    cyc(1, 32'h00400104, 1, 1, 8, 3);
    rst = 1; exc_req = 1;
    cyc(1, 32'h00400000, 0, 0, 0, 0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      j_en = 1; j_index = 26'h0100000;
      cyc(1, 32'h00400000, 1, 0, i + 1, (i < 2) ? i + 1 : 3);
    end
    rst = 1; j_en = 1; j_index = 26'h0100000;
    cyc(1, 32'h00400000, 0, 0, 0, 0);
    rst = 0;
    jr_en = 1; jr_addr = 32'hFFFFFFFC;
    cyc(1, 32'hFFFFFFFC, 1, 0, 1, 1);
    cyc(1, 32'h00000000, 1, 0, 1, 1);
    br_taken = 1; br_imm = 16'hFFFE;
    cyc(1, 32'hFFFFFFFC, 1, 0, 2, 2);
    stall = 1; jr_en = 1; jr_addr = 32'h00000001;
    cyc(1, 32'hFFFFFFFC, 1, 0, 2, 2);
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
